// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the RMII receive state type.
// Used by the receive front end, transmit side and byte assembler.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;
  localparam int ETH_MAX_DIBITS = 6104;

endpackage

// File: rtl/ether_rx.sv
// RMII receive front end: locks on preamble+SFD, strips them and
// forwards frame dibits as a valid/data stream with sof/abort pulses.
// Ports: clk, rst (sync, active-high), crsdv, rxd[1:0] from the PHY;
//        axiov, axiod[1:0], sof, abort (all registered) downstream.
module ether_rx
  import eth_pkg::*;
#(
  parameter int PREAMBLE_MIN = 28,
  parameter int MAX_DIBITS   = ETH_MAX_DIBITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       sof,
  output logic       abort
);

  localparam int PW = (PREAMBLE_MIN < 1) ? 1
                    : $clog2(PREAMBLE_MIN + 1);
  localparam int LW = (MAX_DIBITS < 1) ? 1
                    : $clog2(MAX_DIBITS + 1);

  localparam logic [PW-1:0] PRE_SAT = PW'(PREAMBLE_MIN);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_DIBITS);

  rx_state_t state_q, state_d;

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [LW-1:0] len_cnt_q, len_cnt_d;

  logic       axiov_q, axiov_d;
  logic [1:0] axiod_q, axiod_d;
  logic       sof_q, sof_d;
  logic       abort_q, abort_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Start in DROP so a frame already on the wire is ignored.
      state_q   <= DROP;
      pre_cnt_q <= '0;
      len_cnt_q <= '0;
      axiov_q   <= 1'b0;
      axiod_q   <= 2'b00;
      sof_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      len_cnt_q <= len_cnt_d;
      axiov_q   <= axiov_d;
      axiod_q   <= axiod_d;
      sof_q     <= sof_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    len_cnt_d = len_cnt_q;
    axiov_d   = 1'b0;
    axiod_d   = axiod_q;
    sof_d     = 1'b0;
    abort_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // rxd=00 with carrier is a false-carrier prologue: wait.
        if (crsdv) begin
          if (rxd == PRE_DIBIT) begin
            state_d   = PREAMBLE;
            pre_cnt_d = PW'(1);
          end else if (rxd[1]) begin
            state_d = DROP;
          end
        end
      end

      PREAMBLE: begin
        if (!crsdv) begin
          state_d = IDLE;
        end else if (rxd == PRE_DIBIT) begin
          if (pre_cnt_q < PRE_SAT) begin
            pre_cnt_d = pre_cnt_q + PW'(1);
          end
        end else if (rxd == SFD_DIBIT &&
                     pre_cnt_q >= PRE_SAT) begin
          state_d   = DATA;
          len_cnt_d = '0;
        end else begin
          state_d = DROP;
        end
      end

      DATA: begin
        if (!crsdv) begin
          state_d = IDLE;
        end else if (len_cnt_q == LEN_MAX) begin
          // Overflow dibit is swallowed; stream ends with abort.
          abort_d = 1'b1;
          state_d = DROP;
        end else begin
          axiov_d   = 1'b1;
          axiod_d   = rxd;
          sof_d     = (len_cnt_q == '0);
          len_cnt_d = len_cnt_q + LW'(1);
        end
      end

      DROP: begin
        if (!crsdv) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = DROP;
      end
    endcase
  end

  assign axiov = axiov_q;
  assign axiod = axiod_q;
  assign sof   = sof_q;
  assign abort = abort_q;

endmodule

// File: doc/ether_rx.md
# ether_rx

RMII receive front end for the Ethernet path. Consumes raw `crsdv`/`rxd` dibits from the PHY, locks onto preamble and SFD, and strips them. Forwards frame dibits (destination MAC through FCS) as an `axiov`/`axiod` stream to the CRC checker and the byte assembler. Drops malformed or over-length frames by ending the stream early, which the downstream checker then flags as a bad frame.

## Interface
- `PREAMBLE_MIN`, default 28: minimum number of consecutive `2'b01` dibits required before the SFD dibit `2'b11`.
- `MAX_DIBITS`, default 6104: maximum number of forwarded dibits per frame (1526 bytes).
- `clk` in 1: 50 MHz RMII reference clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `crsdv` in 1: RMII carrier-sense/data-valid. Used as-is; no deglitch.
- `rxd` in 2: RMII receive dibit, LSB dibit first.
- `axiov` out 1: output dibit valid; high for the whole frame body.
- `axiod` out 2: output dibit.
- `sof` out 1: one-cycle pulse on the first `axiov` cycle of a frame.
- `abort` out 1: one-cycle pulse when a frame is truncated for exceeding `MAX_DIBITS`.

## Operation
- Four states: IDLE, PREAMBLE, DATA, DROP.
- Reset state is DROP, so a frame already in progress at reset is ignored.
- DROP:
  - `crsdv`=0 → IDLE.
  - Otherwise stay in DROP.
- IDLE:
  - `crsdv`=0, or `crsdv`=1 with `rxd`=00 → stay in IDLE (false-carrier prologue).
  - `crsdv`=1 with `rxd`=01 → PREAMBLE, `pre_cnt`=1.
  - `crsdv`=1 with `rxd`=10 or 11 → DROP.
- PREAMBLE:
  - `crsdv`=0 → IDLE.
  - `rxd`=01 → `pre_cnt`++, saturating at `PREAMBLE_MIN`.
  - `rxd`=11 with `pre_cnt`≥`PREAMBLE_MIN` → DATA, `len_cnt`=0.
  - `rxd`=11 with `pre_cnt`<`PREAMBLE_MIN` → DROP.
  - `rxd`=00 or 10 → DROP.
- DATA:
  - Each cycle with `crsdv`=1, the dibit is forwarded and `len_cnt`++.
  - `crsdv`=0 → IDLE. End of frame is normal; no `abort`.
  - Overflow: when a dibit arrives with `len_cnt`==`MAX_DIBITS`, that dibit is not forwarded, `abort` pulses, and the state goes to DROP.
- `len_cnt` width is `$clog2(MAX_DIBITS+1)`; it never wraps.
- Odd dibit counts and non-byte-aligned ends are forwarded unchanged. Downstream CRC rejects them.

## Timing
- All outputs are registered. Reset values: `axiov`=0, `axiod`=2'b00, `sof`=0, `abort`=0.
- Latency is 1 cycle. A dibit sampled in DATA at cycle n appears on `axiod` with `axiov`=1 at cycle n+1.
- The SFD dibit is never forwarded. The first forwarded dibit is the one sampled the cycle after the SFD.
- `sof` is high exactly in the first `axiov`=1 cycle of the frame.
- `crsdv` falling in DATA at cycle n:
  - `axiov`=0 at n+1.
  - The last valid dibit was the one sampled at n-1.
- `crsdv` falling in the same cycle as the SFD: no `axiov`, no `sof`; go to IDLE.
- `abort` is asserted in the same cycle `axiov` drops (cycle n+1 for overflow dibit n).
  - `axiov` stays low until a new preamble, even if `crsdv` remains high.
- `axiod` holds its last value when `axiov`=0. Consumers must ignore it.
- `rst` mid-frame: outputs at reset values the next cycle. No further `axiov` until `crsdv` has been low ≥1 cycle and a full preamble+SFD has been seen.
- Back-to-back frames: one cycle of `crsdv`=0 in DATA is sufficient to return to IDLE and accept the next preamble.

## Structure
- Shared package `eth_pkg`:
  - `typedef enum` `rx_state_t` {IDLE, PREAMBLE, DATA, DROP}.
  - Constants `PRE_DIBIT`=2'b01, `SFD_DIBIT`=2'b11, `ETH_MAX_DIBITS`=6104.
  - The same constants are used by the transmit side and the byte assembler.
- Single flat module with no sub-module; the FSM plus two counters are small enough to stay inline.

## Test plan
- Nominal frame: 31×01, 11, then 64 data dibits, `crsdv` low → `axiov` high for exactly 64 cycles starting 1 cycle after the first data dibit; `axiod` matches input; `sof` on the first valid cycle; `abort` never asserted.
- Short preamble: 10×01, 11, data → no `axiov` for the whole carrier period; a following valid frame is received normally.
- Bad preamble dibit: 20×01, 10, 11, data → DROP; no output until `crsdv` falls; the next frame is accepted.
- Over-length, with `MAX_DIBITS`=16: a valid preamble followed by 20 data dibits → exactly 16 forwarded, `abort` pulses once in the cycle `axiov` falls, and nothing further is output.
- Reset mid-DATA after 10 dibits, `crsdv` held high → outputs 0 the next cycle and stay 0 through the rest of that frame; the next full frame after `crsdv` low is received.
- Back-to-back frames separated by a single `crsdv`=0 cycle → two `sof` pulses, with correct dibit counts for each frame.
